// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit for the Mini SRC datapath.
// Fetch occupies T0-T2; the execute steps T3-T7 depend on IR[31:27].
// Every output is decoded from the registered state and the opcode, plus
// CON in the branch-commit step.
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
  output logic        InPortout, Cout, BAout, Rout,
  output logic        PCin, IncPC, MARin, MDRin, IRin, Yin, Zin,
  output logic        HIin, LOin, OutPortin, CONin, Rin,
  output logic        Gra, Grb, Grc,
  output logic        Read, Write,
  output logic [3:0]  alu_op
);
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11, OP_ANDI = 5'd12, OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14, OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16, OP_NOT  = 5'd17, OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19, OP_IN   = 5'd21, OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23, OP_MFLO = 5'd24, OP_HALT = 5'd26;

  localparam logic [3:0] A_ADD = 4'd0, A_AND = 4'd2, A_OR = 4'd3;
  localparam logic [3:0] A_MUL = 4'd8, A_DIV = 4'd9, A_NEG = 4'd10, A_NOT = 4'd11;

  state_t     state, state_nxt;
  logic [4:0] op;
  logic       last;
  logic       is_ralu, is_imm, is_mem, is_muldiv, is_unary, is_br, is_single;
  logic       has_exec;

  assign op        = IR[31:27];
  assign is_ralu   = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_imm    = op inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_mem    = op inside {OP_LD, OP_LDI, OP_ST};
  assign is_muldiv = op inside {OP_MUL, OP_DIV};
  assign is_unary  = op inside {OP_NEG, OP_NOT};
  assign is_br     = (op == OP_BR);
  assign is_single = op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
  // nop, jal and unused encodings have no execute phase at all
  assign has_exec  = is_ralu | is_imm | is_mem | is_muldiv | is_unary | is_br | is_single;

  // State register; Clear abandons any instruction in flight
  always_ff @(posedge Clock) begin
    if (!Clear) state <= S_RESET;
    else        state <= state_nxt;
  end

  // Step decode: control strobes and next state
  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout} = '0;
    {PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin, Rin} = '0;
    {Gra, Grb, Grc, Read, Write} = '0;
    alu_op = A_ADD;
    Run = (state != S_RESET) && (state != S_HALT);

    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        state_nxt = S_T1;
      end
      S_T1: begin
        {Zlowout, PCin, Read, MDRin} = '1;
        state_nxt = S_T2;
      end
      S_T2: begin
        {MDRout, IRin} = '1;
        if (op == OP_HALT) state_nxt = S_HALT;
        else if (has_exec) state_nxt = S_T3;
        else               last = 1'b1;
      end
      S_T3: begin
        state_nxt = S_T4;
        if (is_ralu || is_imm)  {Grb, Rout, Yin} = '1;
        else if (is_mem)        {Grb, BAout, Yin} = '1;
        else if (is_muldiv)     {Gra, Rout, Yin} = '1;
        else if (is_unary) begin
          {Grb, Rout, Zin} = '1;
          alu_op = (op == OP_NEG) ? A_NEG : A_NOT;
        end
        else if (is_br)         {Gra, Rout, CONin} = '1;
        else begin
          last = 1'b1;
          case (op)
            OP_JR:   {Gra, Rout, PCin} = '1;
            OP_IN:   {InPortout, Gra, Rin} = '1;
            OP_OUT:  {Gra, Rout, OutPortin} = '1;
            OP_MFHI: {HIout, Gra, Rin} = '1;
            OP_MFLO: {LOout, Gra, Rin} = '1;
            default: ;
          endcase
        end
      end
      S_T4: begin
        state_nxt = S_T5;
        if (is_ralu) begin
          {Grc, Rout, Zin} = '1;
          alu_op = 4'(op - OP_ADD);
        end
        else if (is_imm) begin
          {Cout, Zin} = '1;
          alu_op = (op == OP_ANDI) ? A_AND : (op == OP_ORI) ? A_OR : A_ADD;
        end
        else if (is_mem)    {Cout, Zin} = '1;
        else if (is_muldiv) begin
          {Grb, Rout, Zin} = '1;
          alu_op = (op == OP_MUL) ? A_MUL : A_DIV;
        end
        else if (is_unary) begin
          {Zlowout, Gra, Rin} = '1;
          last = 1'b1;
        end
        else if (is_br)     {PCout, Yin} = '1;
        else                last = 1'b1;
      end
      S_T5: begin
        state_nxt = S_T6;
        if (is_ralu || is_imm || op == OP_LDI) begin
          {Zlowout, Gra, Rin} = '1;
          last = 1'b1;
        end
        else if (is_mem)    {Zlowout, MARin} = '1;
        else if (is_muldiv) {Zlowout, LOin} = '1;
        else if (is_br)     {Cout, Zin} = '1;
        else                last = 1'b1;
      end
      S_T6: begin
        state_nxt = S_T7;
        if (op == OP_LD)      {Read, MDRin} = '1;
        else if (op == OP_ST) {Gra, Rout, MDRin} = '1;
        else if (is_muldiv) begin
          {Zhighout, HIin} = '1;
          last = 1'b1;
        end
        else if (is_br) begin
          Zlowout = 1'b1;
          PCin    = CON;
          last    = 1'b1;
        end
        else last = 1'b1;
      end
      S_T7: begin
        last = 1'b1;
        if (op == OP_LD)      {MDRout, Gra, Rin} = '1;
        else if (op == OP_ST) Write = 1'b1;
      end
      default: state_nxt = S_HALT;
    endcase

    // Stop only matters on the edge that closes an instruction
    if (last) state_nxt = Stop ? S_HALT : S_T0;
    // alu_op is meaningful only while Z is being loaded
    if (!Zin) alu_op = 4'd0;
  end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit. The stimulus process expands each
// instruction into its per-cycle control word from the step tables and
// queues it; a negedge monitor pops one entry per cycle and compares it.
module tb_control_unit;
  logic        Clock = 1'b0, Clear = 1'b0, CON = 1'b0, Stop = 1'b0;
  logic [31:0] IR = '0;
  logic        Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic        PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin, Rin;
  logic        Gra, Grb, Grc, Read, Write;
  logic [3:0]  alu_op;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .CONin(CONin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Read(Read), .Write(Write), .alu_op(alu_op)
  );

  always #5 Clock = ~Clock;

  // one bit per control line, alu_op in [31:28]
  localparam logic [31:0] PCOUT = 32'h1 << 0,  ZHOUT = 32'h1 << 1,  ZLOUT = 32'h1 << 2;
  localparam logic [31:0] MDROUT = 32'h1 << 3, HIOUT = 32'h1 << 4,  LOOUT = 32'h1 << 5;
  localparam logic [31:0] INPOUT = 32'h1 << 6, COUT = 32'h1 << 7,   BAOUT = 32'h1 << 8;
  localparam logic [31:0] ROUT = 32'h1 << 9,   PCIN = 32'h1 << 10,  INCPC = 32'h1 << 11;
  localparam logic [31:0] MARIN = 32'h1 << 12, MDRIN = 32'h1 << 13, IRIN = 32'h1 << 14;
  localparam logic [31:0] YIN = 32'h1 << 15,   ZIN = 32'h1 << 16,   HIIN = 32'h1 << 17;
  localparam logic [31:0] LOIN = 32'h1 << 18,  OUTPIN = 32'h1 << 19, CONIN = 32'h1 << 20;
  localparam logic [31:0] RIN = 32'h1 << 21,   GRA = 32'h1 << 22,   GRB = 32'h1 << 23;
  localparam logic [31:0] GRC = 32'h1 << 24,   READ = 32'h1 << 25,  WRITE = 32'h1 << 26;
  localparam logic [31:0] RUN = 32'h1 << 27;

  logic [31:0] act;
  assign act = {alu_op, Run, Write, Read, Grc, Grb, Gra, Rin, CONin, OutPortin, LOin, HIin,
                Zin, Yin, IRin, MDRin, MARin, IncPC, PCin, Rout, BAout, Cout, InPortout,
                LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

  typedef struct { logic [31:0] v; string tag; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] steps[$];
  int          total = 0, bad = 0, cyc_n = 0;
  bit          goes_halt;

  // Monitor: one expected control word per cycle, sampled mid-cycle
  always @(negedge Clock) begin
    cyc_n++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, cyc_n, act, e.v);
      end
    end
  end

  task automatic cyc();
    @(posedge Clock); #1;
  endtask

  task automatic push(input logic [31:0] v, input string tag);
    exp_t e;
    e.v = v; e.tag = tag;
    exp_q.push_back(e);
  endtask

  function automatic void step(input logic [31:0] bits, input logic [3:0] alu);
    steps.push_back(bits | RUN | {alu, 28'h0});
  endfunction

  // Reference: the instruction's full step list, fetch included
  function automatic void build(input logic [4:0] op, input logic con);
    logic [3:0] a;
    steps.delete();
    goes_halt = 1'b0;
    step(PCOUT | MARIN | INCPC | ZIN, 4'd0);
    step(ZLOUT | PCIN | READ | MDRIN, 4'd0);
    step(MDROUT | IRIN, 4'd0);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
        case (op)
          5'd3: a = 4'd0;  5'd4: a = 4'd1;  5'd5: a = 4'd2;  5'd6: a = 4'd3;
          5'd7: a = 4'd4;  5'd8: a = 4'd5;  5'd9: a = 4'd6;  default: a = 4'd7;
        endcase
        step(GRB | ROUT | YIN, 4'd0);
        step(GRC | ROUT | ZIN, a);
        step(ZLOUT | GRA | RIN, 4'd0);
      end
      5'd11, 5'd12, 5'd13: begin
        a = (op == 5'd11) ? 4'd0 : (op == 5'd12) ? 4'd2 : 4'd3;
        step(GRB | ROUT | YIN, 4'd0);
        step(COUT | ZIN, a);
        step(ZLOUT | GRA | RIN, 4'd0);
      end
      5'd1: begin
        step(GRB | BAOUT | YIN, 4'd0);
        step(COUT | ZIN, 4'd0);
        step(ZLOUT | GRA | RIN, 4'd0);
      end
      5'd0, 5'd2: begin
        step(GRB | BAOUT | YIN, 4'd0);
        step(COUT | ZIN, 4'd0);
        step(ZLOUT | MARIN, 4'd0);
        if (op == 5'd0) begin
          step(READ | MDRIN, 4'd0);
          step(MDROUT | GRA | RIN, 4'd0);
        end else begin
          step(GRA | ROUT | MDRIN, 4'd0);
          step(WRITE, 4'd0);
        end
      end
      5'd14, 5'd15: begin
        step(GRA | ROUT | YIN, 4'd0);
        step(GRB | ROUT | ZIN, (op == 5'd14) ? 4'd8 : 4'd9);
        step(ZLOUT | LOIN, 4'd0);
        step(ZHOUT | HIIN, 4'd0);
      end
      5'd16, 5'd17: begin
        step(GRB | ROUT | ZIN, (op == 5'd16) ? 4'd10 : 4'd11);
        step(ZLOUT | GRA | RIN, 4'd0);
      end
      5'd18: begin
        step(GRA | ROUT | CONIN, 4'd0);
        step(PCOUT | YIN, 4'd0);
        step(COUT | ZIN, 4'd0);
        step(con ? (ZLOUT | PCIN) : ZLOUT, 4'd0);
      end
      5'd19: step(GRA | ROUT | PCIN, 4'd0);
      5'd21: step(INPOUT | GRA | RIN, 4'd0);
      5'd22: step(GRA | ROUT | OUTPIN, 4'd0);
      5'd23: step(HIOUT | GRA | RIN, 4'd0);
      5'd24: step(LOOUT | GRA | RIN, 4'd0);
      5'd26: goes_halt = 1'b1;
      default: ;
    endcase
  endfunction

  // Runs one instruction from T0; Stop asserted on the final step if asked,
  // and optionally pulsed at random in earlier steps where it must be ignored
  task automatic run_instr(input logic [31:0] ir, input logic con, input bit stop_last,
                           input bit noise, input string tag);
    build(ir[31:27], con);
    IR = ir; CON = con;
    for (int i = 0; i < steps.size(); i++) begin
      Stop = (i == steps.size() - 1) ? stop_last : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      push(steps[i], $sformatf("%s.s%0d", tag, i));
      cyc();
    end
    Stop = 1'b0;
    if (stop_last) goes_halt = 1'b1;
  endtask

  task automatic hold_halt(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      Stop = 1'($urandom_range(0, 1));
      push(32'h0, tag);
      cyc();
    end
    Stop = 1'b0;
  endtask

  // From Reset or Halt: one cycle with Clear low, then release into T0
  task automatic do_reset(input string tag);
    Clear = 1'b0;
    push(32'h0, tag);
    cyc();
    Clear = 1'b1;
    push(32'h0, tag);
    cyc();
  endtask

  initial begin
    logic [31:0] ir;
    Clear = 1'b0;
    cyc();
    do_reset("reset");

    run_instr(32'h6108001A, 1'b0, 1'b0, 1'b0, "andi");
    run_instr(32'h00800055, 1'b0, 1'b0, 1'b0, "ld");
    run_instr(32'h91000023, 1'b0, 1'b0, 1'b0, "br_con0");
    run_instr(32'h91000023, 1'b1, 1'b0, 1'b0, "br_con1");
    run_instr(32'h71100000, 1'b0, 1'b0, 1'b0, "mul");
    run_instr(32'hC0800000, 1'b0, 1'b0, 1'b0, "mflo");
    run_instr(32'h18880000, 1'b0, 1'b0, 1'b1, "add_noise");
    run_instr(32'hC8000000, 1'b0, 1'b0, 1'b0, "nop");

    run_instr(32'hD0000000, 1'b0, 1'b0, 1'b0, "halt");
    hold_halt(20, "halt_hold");
    do_reset("halt_exit");

    run_instr(32'h18880000, 1'b0, 1'b1, 1'b0, "add_stop");
    hold_halt(5, "stop_hold");
    do_reset("stop_exit");

    // st abandoned in T4 by Clear
    build(5'd2, 1'b0);
    IR = 32'h10800010;
    for (int i = 0; i <= 4; i++) begin
      if (i == 4) Clear = 1'b0;
      push(steps[i], $sformatf("st_abort.s%0d", i));
      cyc();
    end
    Clear = 1'b1;
    push(32'h0, "st_abort.reset");
    cyc();
    run_instr(32'h10800010, 1'b0, 1'b0, 1'b0, "st_after");

    for (int n = 0; n < 40; n++) begin
      ir = $urandom;
      run_instr(ir, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'b1,
                $sformatf("rnd%0d_op%0d", n, ir[31:27]));
      if (goes_halt) begin
        hold_halt(3, "rnd_halt");
        do_reset("rnd_reset");
      end
    end

    cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d need=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end
endmodule
